// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift/rotate execution unit built around a 16-bit
// rotate-right barrel core, with valid/ready handshakes on issue and writeback.

module shift_exec_rotr #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [SHW-1:0]   b,
    output logic [WIDTH-1:0] o
);
    // Logarithmic barrel: stage k rotates right by 2**k when b[k] is set.
    always_comb begin
        o = a;
        for (int k = 0; k < SHW; k++) begin
            if (b[k]) begin
                o = (o >> (1 << k)) | (o << (WIDTH - (1 << k)));
            end
        end
    end
endmodule

module shift_exec_stage #(
    parameter int WIDTH = 16,
    parameter int SHW   = 4,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [2:0]       in_op,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_err,
    output logic [TAGW-1:0]  out_tag
);
    typedef enum logic [2:0] {
        OP_ROR = 3'b000,
        OP_ROL = 3'b001,
        OP_SRL = 3'b010,
        OP_SLL = 3'b011,
        OP_SRA = 3'b100
    } op_e;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [SHW-1:0]   s1_shamt;
    logic [2:0]       s1_op;
    logic [TAGW-1:0]  s1_tag;

    logic             adv;
    logic             accept;
    op_e              s1_op_e;
    logic             left_op;
    logic [SHW-1:0]   rot_amt;
    logic [SHW-1:0]   shamt_m1;
    logic             shamt_nz;
    logic [WIDTH-1:0] rot_out;
    logic [WIDTH-1:0] mask_r;
    logic [WIDTH-1:0] mask_l;
    logic [WIDTH-1:0] res;
    logic             res_carry;
    logic             res_err;

    assign adv      = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_shamt <= '0;
            s1_op    <= '0;
            s1_tag   <= '0;
        end else begin
            s1_valid <= accept || (s1_valid && !adv);
            if (accept) begin
                s1_data  <= in_data;
                s1_shamt <= in_shamt;
                s1_op    <= in_op;
                s1_tag   <= in_tag;
            end
        end
    end

    // Left shifts/rotates reuse the right-rotate core with amount (16 - n) mod 16.
    assign s1_op_e  = op_e'(s1_op);
    assign left_op  = (s1_op_e == OP_ROL) || (s1_op_e == OP_SLL);
    assign rot_amt  = left_op ? (SHW'(0) - s1_shamt) : s1_shamt;
    assign shamt_m1 = s1_shamt - SHW'(1);
    assign shamt_nz = |s1_shamt;
    assign mask_r   = {WIDTH{1'b1}} >> s1_shamt;
    assign mask_l   = {WIDTH{1'b1}} << s1_shamt;

    shift_exec_rotr #(
        .WIDTH(WIDTH),
        .SHW  (SHW)
    ) u_rotr (
        .a(s1_data),
        .b(rot_amt),
        .o(rot_out)
    );

    always_comb begin
        res       = s1_data;
        res_carry = 1'b0;
        res_err   = 1'b0;
        case (s1_op_e)
            OP_ROR: begin
                res       = rot_out;
                res_carry = shamt_nz & rot_out[WIDTH-1];
            end
            OP_ROL: begin
                res       = rot_out;
                res_carry = shamt_nz & rot_out[0];
            end
            OP_SRL: begin
                res       = rot_out & mask_r;
                res_carry = shamt_nz & s1_data[shamt_m1];
            end
            OP_SLL: begin
                res       = rot_out & mask_l;
                res_carry = shamt_nz & s1_data[rot_amt];
            end
            OP_SRA: begin
                res       = (rot_out & mask_r) | ({WIDTH{s1_data[WIDTH-1]}} & ~mask_r);
                res_carry = shamt_nz & s1_data[shamt_m1];
            end
            default: begin
                res_err = 1'b1;
            end
        endcase
    end

    // Output registers hold while the consumer stalls; drain clears valid only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_carry <= 1'b0;
            out_zero  <= 1'b0;
            out_err   <= 1'b0;
            out_tag   <= '0;
        end else if (s1_valid && adv) begin
            out_valid <= 1'b1;
            out_data  <= res;
            out_carry <= res_carry;
            out_zero  <= (res == '0);
            out_err   <= res_err;
            out_tag   <= s1_tag;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vectors, backpressure
// stream, randomized traffic against an arithmetic reference model, and reset.

module tb_shift_exec_stage;
    localparam int WIDTH = 16;
    localparam int SHW   = 4;
    localparam int TAGW  = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [SHW-1:0]   in_shamt;
    logic [2:0]       in_op;
    logic [TAGW-1:0]  in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             out_zero;
    logic             out_err;
    logic [TAGW-1:0]  out_tag;

    typedef struct packed {
        logic        err;
        logic        zero;
        logic        carry;
        logic [3:0]  tag;
        logic [15:0] data;
    } res_t;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  n;
        logic [2:0]  op;
        logic [15:0] xd;
        logic        xc;
        logic        xz;
        logic        xe;
    } vec_t;

    int   n_vec  = 0;
    int   n_fail = 0;
    res_t exp_q[$];

    shift_exec_stage #(
        .WIDTH(WIDTH),
        .SHW  (SHW),
        .TAGW (TAGW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_shamt (in_shamt),
        .in_op    (in_op),
        .in_tag   (in_tag),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry),
        .out_zero (out_zero),
        .out_err  (out_err),
        .out_tag  (out_tag)
    );

    always #5 clk = ~clk;

    // Reference: plain shifts on a wide value, sign-extending shift for SRA.
    function automatic res_t ref_model(input logic [15:0] d, input logic [3:0] n,
                                       input logic [2:0] op, input logic [3:0] tag);
        res_t        r;
        int          nn;
        logic [31:0] dd;
        nn      = int'(n);
        dd      = {16'h0000, d};
        r.data  = d;
        r.carry = 1'b0;
        r.err   = 1'b0;
        r.tag   = tag;
        case (op)
            3'd0: r.data = 16'((dd >> nn) | (dd << (16 - nn)));
            3'd1: r.data = 16'((dd << nn) | (dd >> (16 - nn)));
            3'd2: r.data = d >> nn;
            3'd3: r.data = 16'(dd << nn);
            3'd4: r.data = 16'($signed(d) >>> nn);
            default: r.err = 1'b1;
        endcase
        if (nn > 0 && !r.err) begin
            case (op)
                3'd0:    r.carry = r.data[15];
                3'd1:    r.carry = r.data[0];
                3'd3:    r.carry = d[16 - nn];
                default: r.carry = d[nn - 1];
            endcase
        end
        r.zero = (r.data == 16'h0000);
        return r;
    endfunction

    function automatic res_t cur_out();
        res_t r;
        r.err   = out_err;
        r.zero  = out_zero;
        r.carry = out_carry;
        r.tag   = out_tag;
        r.data  = out_data;
        return r;
    endfunction

    // Drives a single request, waits (bounded) for its result and captures it.
    task automatic issue_one(input logic [15:0] d, input logic [3:0] n, input logic [2:0] op,
                             input logic [3:0] tag, output res_t got, output int lat);
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = n;
        in_op     = op;
        in_tag    = tag;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat      = 1;
        while (!out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        got = cur_out();
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_op     = '0;
        in_tag    = '0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur_out() !== res_t'(0)) begin
            n_fail++;
            $display("[TB] FAIL reset_hold: valid=%b ready=%b out=%h, want valid=0 ready=1 out=0",
                     out_valid, in_ready, cur_out());
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur_out() !== res_t'(0)) begin
            n_fail++;
            $display("[TB] FAIL reset_release: valid=%b ready=%b out=%h, want valid=0 ready=1 out=0",
                     out_valid, in_ready, cur_out());
        end
    endtask

    task automatic test_directed();
        vec_t tbl[7];
        res_t got;
        int   lat;
        tbl = '{
            '{16'h8001, 4'd1,  3'd2, 16'h4000, 1'b1, 1'b0, 1'b0},
            '{16'h8000, 4'd15, 3'd4, 16'hFFFF, 1'b0, 1'b0, 1'b0},
            '{16'h7FFF, 4'd4,  3'd4, 16'h07FF, 1'b1, 1'b0, 1'b0},
            '{16'h0001, 4'd15, 3'd3, 16'h8000, 1'b0, 1'b0, 1'b0},
            '{16'h8000, 4'd1,  3'd3, 16'h0000, 1'b1, 1'b1, 1'b0},
            '{16'h1234, 4'd4,  3'd1, 16'h2341, 1'b1, 1'b0, 1'b0},
            '{16'h1234, 4'd4,  3'd0, 16'h4123, 1'b0, 1'b0, 1'b0}
        };
        for (int i = 0; i < 7; i++) begin
            issue_one(tbl[i].d, tbl[i].n, tbl[i].op, 4'(i), got, lat);
            n_vec++;
            if (lat != 2 || got.data !== tbl[i].xd || got.carry !== tbl[i].xc ||
                got.zero !== tbl[i].xz || got.err !== tbl[i].xe || got.tag !== 4'(i)) begin
                n_fail++;
                $display("[TB] FAIL directed[%0d]: got d=%h c=%b z=%b e=%b tag=%h lat=%0d, want d=%h c=%b z=%b e=%b tag=%h lat=2",
                         i, got.data, got.carry, got.zero, got.err, got.tag, lat,
                         tbl[i].xd, tbl[i].xc, tbl[i].xz, tbl[i].xe, 4'(i));
            end
        end
    endtask

    task automatic test_shift_zero();
        res_t got;
        int   lat;
        for (int op = 0; op < 5; op++) begin
            issue_one(16'hA5A5, 4'd0, 3'(op), 4'(op + 8), got, lat);
            n_vec++;
            if (lat != 2 || got.data !== 16'hA5A5 || got.carry !== 1'b0 ||
                got.zero !== 1'b0 || got.err !== 1'b0 || got.tag !== 4'(op + 8)) begin
                n_fail++;
                $display("[TB] FAIL shift_zero[op%0d]: got d=%h c=%b z=%b e=%b tag=%h lat=%0d, want d=a5a5 c=0 z=0 e=0 tag=%h lat=2",
                         op, got.data, got.carry, got.zero, got.err, got.tag, lat, 4'(op + 8));
            end
        end
    endtask

    task automatic test_illegal();
        res_t got;
        int   lat;
        for (int op = 5; op < 8; op++) begin
            issue_one(16'h00F0, 4'(op - 2), 3'(op), 4'(op), got, lat);
            n_vec++;
            if (lat != 2 || got.data !== 16'h00F0 || got.carry !== 1'b0 ||
                got.zero !== 1'b0 || got.err !== 1'b1 || got.tag !== 4'(op)) begin
                n_fail++;
                $display("[TB] FAIL illegal[op%0d]: got d=%h c=%b z=%b e=%b tag=%h lat=%0d, want d=00f0 c=0 z=0 e=1 tag=%h lat=2",
                         op, got.data, got.carry, got.zero, got.err, got.tag, lat, 4'(op));
            end
        end
        issue_one(16'h0000, 4'd7, 3'd5, 4'd3, got, lat);
        n_vec++;
        if (got.data !== 16'h0000 || got.zero !== 1'b1 || got.err !== 1'b1 || got.carry !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL illegal_zero: got d=%h c=%b z=%b e=%b, want d=0000 c=0 z=1 e=1",
                     got.data, got.carry, got.zero, got.err);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d[6];
        logic [3:0]  n[6];
        logic [2:0]  op[6];
        res_t        exp, got, prev;
        logic        prev_stall;
        int          next_tag, got_cnt, c;
        for (int i = 0; i < 6; i++) begin
            d[i]  = 16'($urandom);
            n[i]  = 4'($urandom_range(1, 15));
            op[i] = 3'($urandom_range(0, 4));
        end
        exp_q.delete();
        prev       = '0;
        prev_stall = 1'b0;
        next_tag   = 0;
        got_cnt    = 0;
        c          = 0;
        while (got_cnt < 6 && c < 40) begin
            @(negedge clk);
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || cur_out() !== prev) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_stall_hold: cycle %0d got valid=%b out=%h, want valid=1 out=%h",
                             c, out_valid, cur_out(), prev);
                end
            end
            if (c == 1 || c == 2) begin
                n_vec++;
                if (out_valid !== (c == 2)) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_first_valid: cycle %0d got out_valid=%b, want %b",
                             c, out_valid, (c == 2));
                end
            end
            out_ready = !(c >= 3 && c <= 5);
            in_valid  = (next_tag < 6);
            if (next_tag < 6) begin
                in_data  = d[next_tag];
                in_shamt = n[next_tag];
                in_op    = op[next_tag];
                in_tag   = 4'(next_tag);
            end
            #1;
            if (c == 3) begin
                n_vec++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_full_ready: got in_ready=%b, want 0", in_ready);
                end
            end
            n_vec++;
            if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
                n_fail++;
                $display("[TB] FAIL b2b_in_ready: cycle %0d got %b, want %b",
                         c, in_ready, ((exp_q.size() < 2) || out_ready));
            end
            if (out_valid && out_ready) begin
                n_vec++;
                got = cur_out();
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL b2b_spurious: got out=%h, want no result", got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL b2b_result[%0d]: got out=%h, want %h", got_cnt, got, exp);
                    end
                end
                got_cnt++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_data, in_shamt, in_op, in_tag));
                next_tag++;
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur_out();
            c++;
        end
        in_valid = 1'b0;
        n_vec++;
        if (got_cnt != 6 || exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL b2b_complete: got %0d results (%0d pending), want 6 (0 pending)",
                     got_cnt, exp_q.size());
        end
    endtask

    task automatic test_random(input int cycles);
        res_t exp, got, prev;
        logic prev_stall;
        exp_q.delete();
        prev       = '0;
        prev_stall = 1'b0;
        for (int c = 0; c < cycles + 40; c++) begin
            @(negedge clk);
            if (prev_stall) begin
                n_vec++;
                if (out_valid !== 1'b1 || cur_out() !== prev) begin
                    n_fail++;
                    $display("[TB] FAIL rand_stall_hold: cycle %0d got valid=%b out=%h, want valid=1 out=%h",
                             c, out_valid, cur_out(), prev);
                end
            end
            out_ready = (c >= cycles) ? 1'b1 : ($urandom_range(0, 3) != 0);
            in_valid  = (c < cycles) && ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            in_shamt  = 4'($urandom);
            in_op     = 3'($urandom_range(0, 7));
            in_tag    = 4'($urandom);
            #1;
            n_vec++;
            if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
                n_fail++;
                $display("[TB] FAIL rand_in_ready: cycle %0d got %b, want %b",
                         c, in_ready, ((exp_q.size() < 2) || out_ready));
            end
            if (out_valid && out_ready) begin
                n_vec++;
                got = cur_out();
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL rand_spurious: cycle %0d got out=%h, want no result", c, got);
                end else begin
                    exp = exp_q.pop_front();
                    if (got !== exp) begin
                        n_fail++;
                        $display("[TB] FAIL rand_result: cycle %0d got out=%h, want %h", c, got, exp);
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_model(in_data, in_shamt, in_op, in_tag));
            end
            prev_stall = out_valid && !out_ready;
            prev       = cur_out();
        end
        in_valid = 1'b0;
        n_vec++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL rand_drain: got %0d pending valid=%b, want 0 pending valid=0",
                     exp_q.size(), out_valid);
        end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_shamt  = 4'd4;
        in_op     = 3'd0;
        in_tag    = 4'd5;
        @(negedge clk);
        in_data = 16'h8001;
        in_op   = 3'd2;
        in_tag  = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL inflight_setup: got valid=%b ready=%b, want valid=1 ready=0",
                     out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || cur_out() !== res_t'(0)) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got valid=%b ready=%b out=%h, want valid=0 ready=1 out=0",
                     out_valid, in_ready, cur_out());
        end
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("[TB] FAIL post_reset_emit: cycle %0d got out_valid=1 tag=%h, want 0", i, out_tag);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_directed();
        test_shift_zero();
        test_illegal();
        test_back_to_back();
        test_random(400);
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
